// File: rtl/sgn_sum_window_acc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sgn_sum_window_acc
//
// Purpose:
//   Consumes the signed BW+1-bit sums produced by the three-operand adder
//   stage and totals them over a window of up to WIN samples.
//   The window can also be closed early by in_last.
//   The total saturates to OW-bit signed range, and each window result
//   carries a sample count and a sticky saturation flag.
//   The result is held on a valid/ready output until the next stage takes it.
//
// Parameters:
//   BW  - upstream operand width; in_sum is BW+1 bits signed
//   WIN - maximum samples per window (>= 1)
//   OW  - accumulator/output width, signed (>= BW+1)
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_valid  in   upstream sum valid
//   in_ready  out  a sample can be accepted this cycle
//   in_sum    in   signed sum (BW+1 bits)
//   in_last   in   close the window after this sample
//   out_valid out  window result valid
//   out_ready in   downstream accepts the result
//   out_acc   out  saturated signed window total (OW bits)
//   out_cnt   out  samples in the window, 1..WIN
//   out_sat   out  saturation happened somewhere in this window
//
// Optional feature (macro SGN_WINDOW_ACC_FAST_RESTART_EN):
//   When defined, a sample may be accepted in the same cycle as the output
//   handshake. That sample starts the next window, which gives back-to-back
//   windows with no idle cycle.
//   When undefined, in_ready stays low for the whole HOLD state.
// -----------------------------------------------------------------------------
module sgn_sum_window_acc #(
  parameter int BW  = 8,
  parameter int WIN = 4,
  parameter int OW  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BW:0]                in_sum,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OW-1:0]              out_acc,
  output logic [$clog2(WIN+1)-1:0]   out_cnt,
  output logic                       out_sat
);

  localparam int CW = $clog2(WIN+1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t        state;
  logic [OW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          sat;

  logic [OW:0]   ext_sum;
  logic [OW:0]   nxt;
  logic          pos_ovf;
  logic          neg_ovf;
  logic [OW-1:0] clamped;
  logic [CW-1:0] cnt_inc;
  logic          closes;
  logic          accept;

  // The sum is formed one bit wider than the accumulator, so it cannot wrap.
  // The top two bits then show directly which way it left the OW-bit range.
  always_comb begin
    ext_sum = {{(OW-BW){in_sum[BW]}}, in_sum};
    nxt     = {acc[OW-1], acc} + ext_sum;
    pos_ovf = ~nxt[OW] &  nxt[OW-1];
    neg_ovf =  nxt[OW] & ~nxt[OW-1];
    if (pos_ovf)
      clamped = {1'b0, {(OW-1){1'b1}}};
    else if (neg_ovf)
      clamped = {1'b1, {(OW-1){1'b0}}};
    else
      clamped = nxt[OW-1:0];
    cnt_inc = cnt + CW'(1);
    closes  = in_last || (cnt_inc == CW'(WIN));
  end

`ifdef SGN_WINDOW_ACC_FAST_RESTART_EN
  assign in_ready = (state == ACCUM) ? 1'b1 : out_ready;
`else
  assign in_ready = (state == ACCUM);
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= clamped;
            cnt <= cnt_inc;
            sat <= sat | pos_ovf | neg_ovf;
            if (closes) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_acc   <= clamped;
              out_cnt   <= cnt_inc;
              out_sat   <= sat | pos_ovf | neg_ovf;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            state     <= ACCUM;
            out_valid <= 1'b0;
`ifdef SGN_WINDOW_ACC_FAST_RESTART_EN
            // A sample taken during the handshake opens the next window.
            // The sample cannot saturate on its own, because OW >= BW+1.
            if (in_valid) begin
              acc <= ext_sum[OW-1:0];
              cnt <= CW'(1);
              if (in_last || (WIN == 1)) begin
                acc       <= '0;
                cnt       <= '0;
                state     <= HOLD;
                out_valid <= 1'b1;
                out_acc   <= ext_sum[OW-1:0];
                out_cnt   <= CW'(1);
                out_sat   <= 1'b0;
              end
            end
`endif
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
